hdmi_video_timing_gen: RTL and testbench

//  Programmable video timing generator and pixel-stream aligner for the HDMI output path.

---
 rtl/hdmi_video_timing_gen.sv | 167 ++++++++++++++++
 tb/tb_hdmi_video_timing_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing_gen.sv
// Programmable HDMI video timing generator with per-frame shadowed timing,
// SOF-based stream alignment and underflow accounting.
module hdmi_video_timing_gen #(
    parameter int DATA_WIDTH = 24,
    parameter int H_BITS     = 12,
    parameter int V_BITS     = 12,
    parameter int CNT_BITS   = 16
) (
    input  logic                  ACLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic [H_BITS-1:0]     H_ACTIVE,
    input  logic [H_BITS-1:0]     H_FP,
    input  logic [H_BITS-1:0]     H_SYNC,
    input  logic [H_BITS-1:0]     H_BP,
    input  logic [V_BITS-1:0]     V_ACTIVE,
    input  logic [V_BITS-1:0]     V_FP,
    input  logic [V_BITS-1:0]     V_SYNC,
    input  logic [V_BITS-1:0]     V_BP,
    input  logic                  HS_POL,
    input  logic                  VS_POL,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    input  logic                  S_SOF,
    output logic                  HDMI_DE,
    output logic                  HDMI_HSYNC,
    output logic                  HDMI_VSYNC,
    output logic [DATA_WIDTH-1:0] HDMI_DATA,
    output logic                  FRAME_START,
    output logic                  UNDERFLOW,
    output logic [CNT_BITS-1:0]   UNDERFLOW_CNT
);

    localparam int HW = H_BITS + 2;
    localparam int VW = V_BITS + 2;

    typedef enum logic [1:0] {IDLE, SEEK, LOCK} state_t;

    state_t state, state_nx;

    logic [H_BITS-1:0] h_act_s, h_fp_s, h_sync_s, h_bp_s;
    logic [V_BITS-1:0] v_act_s, v_fp_s, v_sync_s, v_bp_s;

    logic [HW-1:0] h_cnt, h_sync_beg, h_sync_end, h_tot;
    logic [VW-1:0] v_cnt, v_sync_beg, v_sync_end, v_tot;

    logic running, h_last, v_last, frame_wrap, active, at_origin;
    logic in_hsync, in_vsync, shadow_load, s_ready_c, en_p0, underflow_c;

    logic                  de_p1, hs_p1, vs_p1, fs_p1, uf_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [CNT_BITS-1:0]   uf_cnt_p1;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
        return (&c) ? c : c + CNT_BITS'(1);
    endfunction

    // Segment boundaries derived from the shadowed (frame-stable) timing
    assign h_sync_beg = HW'(h_act_s) + HW'(h_fp_s);
    assign h_sync_end = h_sync_beg + HW'(h_sync_s);
    assign h_tot      = h_sync_end + HW'(h_bp_s);
    assign v_sync_beg = VW'(v_act_s) + VW'(v_fp_s);
    assign v_sync_end = v_sync_beg + VW'(v_sync_s);
    assign v_tot      = v_sync_end + VW'(v_bp_s);

    assign running     = (state != IDLE);
    assign h_last      = (h_cnt == h_tot - HW'(1));
    assign v_last      = (v_cnt == v_tot - VW'(1));
    assign frame_wrap  = running && h_last && v_last;
    assign active      = (h_cnt < HW'(h_act_s)) && (v_cnt < VW'(v_act_s));
    assign at_origin   = (h_cnt == '0) && (v_cnt == '0);
    assign in_hsync    = (h_cnt >= h_sync_beg) && (h_cnt < h_sync_end);
    assign in_vsync    = (v_cnt >= v_sync_beg) && (v_cnt < v_sync_end);
    assign shadow_load = ((state == IDLE) && EN) || frame_wrap;
    assign underflow_c = (state == LOCK) && active && !S_VALID;

    always_comb begin
        s_ready_c = 1'b0;
        case (state)
            SEEK:    s_ready_c = !S_SOF;
            LOCK:    s_ready_c = active && S_VALID && (!S_SOF || at_origin);
            default: s_ready_c = 1'b0;
        endcase
    end

    assign S_READY = s_ready_c;

    // A beat whose SOF flag disagrees with the (0,0) position breaks lock
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (EN) state_nx = SEEK;
            SEEK:    if (frame_wrap && S_VALID && S_SOF) state_nx = LOCK;
            LOCK:    if (active && S_VALID && (S_SOF != at_origin)) state_nx = SEEK;
            default: state_nx = IDLE;
        endcase
        if (frame_wrap && !EN) state_nx = IDLE;
    end

    always_ff @(posedge ACLK) begin
        if (shadow_load) begin
            h_act_s  <= H_ACTIVE;
            h_fp_s   <= H_FP;
            h_sync_s <= H_SYNC;
            h_bp_s   <= H_BP;
            v_act_s  <= V_ACTIVE;
            v_fp_s   <= V_FP;
            v_sync_s <= V_SYNC;
            v_bp_s   <= V_BP;
        end
    end

    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
            en_p0 <= 1'b0;
        end else begin
            state <= state_nx;
            en_p0 <= EN;
            if (!running) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end else if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // Output stage: registered one cycle behind the counters
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            de_p1     <= 1'b0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            fs_p1     <= 1'b0;
            uf_p1     <= 1'b0;
            data_p1   <= '0;
            uf_cnt_p1 <= '0;
        end else begin
            de_p1   <= running && active;
            hs_p1   <= (running && in_hsync) ? HS_POL : !HS_POL;
            vs_p1   <= (running && in_vsync) ? VS_POL : !VS_POL;
            fs_p1   <= running && at_origin;
            uf_p1   <= underflow_c;
            data_p1 <= ((state == LOCK) && s_ready_c) ? S_DATA : '0;
            if (EN && !en_p0)
                uf_cnt_p1 <= '0;
            else if (underflow_c)
                uf_cnt_p1 <= sat_inc(uf_cnt_p1);
        end
    end

    assign HDMI_DE       = de_p1;
    assign HDMI_HSYNC    = hs_p1;
    assign HDMI_VSYNC    = vs_p1;
    assign HDMI_DATA     = data_p1;
    assign FRAME_START   = fs_p1;
    assign UNDERFLOW     = uf_p1;
    assign UNDERFLOW_CNT = uf_cnt_p1;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen: 8x5 (and 10x5) frames checked
// cycle by cycle against hand-derived DE/sync masks and pixel tables.
module tb_hdmi_video_timing_gen;

    localparam int DW = 24;
    localparam int HB = 12;
    localparam int VB = 12;
    localparam int CB = 16;

    logic          ACLK = 1'b0;
    logic          RST, EN;
    logic [HB-1:0] H_ACTIVE, H_FP, H_SYNC, H_BP;
    logic [VB-1:0] V_ACTIVE, V_FP, V_SYNC, V_BP;
    logic          HS_POL, VS_POL;
    logic          S_VALID, S_READY, S_SOF;
    logic [DW-1:0] S_DATA;
    logic          HDMI_DE, HDMI_HSYNC, HDMI_VSYNC, FRAME_START, UNDERFLOW;
    logic [DW-1:0] HDMI_DATA;
    logic [CB-1:0] UNDERFLOW_CNT;

    hdmi_video_timing_gen #(.DATA_WIDTH(DW), .H_BITS(HB), .V_BITS(VB), .CNT_BITS(CB)) dut (
        .ACLK(ACLK), .RST(RST), .EN(EN),
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA), .S_SOF(S_SOF),
        .HDMI_DE(HDMI_DE), .HDMI_HSYNC(HDMI_HSYNC), .HDMI_VSYNC(HDMI_VSYNC),
        .HDMI_DATA(HDMI_DATA), .FRAME_START(FRAME_START), .UNDERFLOW(UNDERFLOW),
        .UNDERFLOW_CNT(UNDERFLOW_CNT)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic          sof;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] exp_data [50];
    logic          exp_uf   [50];
    logic          exp_rdy  [50];
    logic          drop     [50];
    logic          drop_now = 1'b0;
    logic          rdy_seen, fire;
    logic [4:0]    de_v = 5'b00011;
    logic [4:0]    vs_v = 5'b01000;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] base, input int n, input logic with_sof);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.sof  = with_sof && (k == 0);
            b.data = base + DW'(k);
            q.push_back(b);
        end
    endtask

    task automatic tick();
        if (q.size() > 0) begin
            S_DATA  = q[0].data;
            S_SOF   = q[0].sof;
            S_VALID = !drop_now;
        end else begin
            S_DATA  = '0;
            S_SOF   = 1'b0;
            S_VALID = 1'b0;
        end
        @(negedge ACLK);
        rdy_seen = S_READY;
        fire     = S_VALID && S_READY;
        @(posedge ACLK);
        #1;
        if (fire) void'(q.pop_front());
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 50; i++) begin
            exp_data[i] = '0;
            exp_uf[i]   = 1'b0;
            exp_rdy[i]  = 1'b0;
            drop[i]     = 1'b0;
        end
    endtask

    task automatic lock_frame(input logic [DW-1:0] base, input int htot, input int hact);
        int k;
        k = 0;
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < hact; h++) begin
                exp_data[v*htot+h] = base + DW'(k);
                exp_rdy[v*htot+h]  = 1'b1;
                k++;
            end
    endtask

    // Caller enters with the counters at frame position 0
    task automatic run_frame(input int fr, input int htot, input logic [15:0] de_h,
                             input logic [15:0] hs_h, input logic pol,
                             input int hact_pos, input int enoff_pos);
        int h, v;
        for (int p = 0; p < htot*5; p++) begin
            if (p == hact_pos) H_ACTIVE = 12'd6;
            if (p == enoff_pos) EN = 1'b0;
            drop_now = drop[p];
            tick();
            h = p % htot;
            v = p / htot;
            chk($sformatf("f%0d p%0d DE", fr, p), 32'(HDMI_DE), 32'(de_h[h] & de_v[v]));
            chk($sformatf("f%0d p%0d HSYNC", fr, p), 32'(HDMI_HSYNC), 32'(hs_h[h] ? pol : !pol));
            chk($sformatf("f%0d p%0d VSYNC", fr, p), 32'(HDMI_VSYNC), 32'(vs_v[v] ? pol : !pol));
            chk($sformatf("f%0d p%0d FRAME_START", fr, p), 32'(FRAME_START), 32'(p == 0));
            chk($sformatf("f%0d p%0d DATA", fr, p), 32'(HDMI_DATA), 32'(exp_data[p]));
            chk($sformatf("f%0d p%0d UNDERFLOW", fr, p), 32'(UNDERFLOW), 32'(exp_uf[p]));
            chk($sformatf("f%0d p%0d S_READY", fr, p), 32'(rdy_seen), 32'(exp_rdy[p]));
        end
        drop_now = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; EN = 1'b0;
        H_ACTIVE = 12'd4; H_FP = 12'd1; H_SYNC = 12'd2; H_BP = 12'd1;
        V_ACTIVE = 12'd2; V_FP = 12'd1; V_SYNC = 12'd1; V_BP = 12'd1;
        HS_POL = 1'b0; VS_POL = 1'b0;
        S_VALID = 1'b0; S_SOF = 1'b0; S_DATA = '0;
        clear_exp();

        // Reset: every output low, then idle syncs settle to ~POL
        @(posedge ACLK); @(posedge ACLK); #1;
        chk("rst DE", 32'(HDMI_DE), 32'd0);
        chk("rst HSYNC", 32'(HDMI_HSYNC), 32'd0);
        chk("rst VSYNC", 32'(HDMI_VSYNC), 32'd0);
        chk("rst DATA", 32'(HDMI_DATA), 32'd0);
        chk("rst FRAME_START", 32'(FRAME_START), 32'd0);
        chk("rst UNDERFLOW", 32'(UNDERFLOW), 32'd0);
        chk("rst UNDERFLOW_CNT", 32'(UNDERFLOW_CNT), 32'd0);
        chk("rst S_READY", 32'(S_READY), 32'd0);
        RST = 1'b0;
        tick();
        chk("idle HSYNC", 32'(HDMI_HSYNC), 32'd1);
        chk("idle VSYNC", 32'(HDMI_VSYNC), 32'd1);
        chk("idle DE", 32'(HDMI_DE), 32'd0);

        // Active-low syncs over one SEEK frame, EN dropped at once
        EN = 1'b1;
        tick();
        clear_exp();
        for (int i = 0; i < 40; i++) exp_rdy[i] = 1'b1;
        run_frame(100, 8, 16'h000F, 16'h0060, 1'b0, -1, 0);
        tick();
        chk("t2 idle DE", 32'(HDMI_DE), 32'd0);
        chk("t2 idle FRAME_START", 32'(FRAME_START), 32'd0);
        chk("t2 idle HSYNC", 32'(HDMI_HSYNC), 32'd1);

        // Junk, then aligned frames; all stream data queued up front
        HS_POL = 1'b1; VS_POL = 1'b1;
        tick();
        push_frame(24'hAA0000, 3, 1'b0);
        push_frame(24'h000100, 8, 1'b1);
        push_frame(24'h000200, 8, 1'b1);
        push_frame(24'h000300, 6, 1'b1);
        push_frame(24'h000400, 6, 1'b1);
        push_frame(24'h000500, 8, 1'b1);
        push_frame(24'h000600, 8, 1'b1);
        push_frame(24'h000700, 12, 1'b1);
        EN = 1'b1;
        tick();
        chk("seek UNDERFLOW_CNT", 32'(UNDERFLOW_CNT), 32'd0);

        clear_exp();
        exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
        run_frame(0, 8, 16'h000F, 16'h0060, 1'b1, -1, -1);

        clear_exp(); lock_frame(24'h000100, 8, 4);
        run_frame(1, 8, 16'h000F, 16'h0060, 1'b1, -1, -1);
        clear_exp(); lock_frame(24'h000200, 8, 4);
        run_frame(2, 8, 16'h000F, 16'h0060, 1'b1, -1, -1);

        // Two starved pixels
        clear_exp();
        exp_data[0]  = 24'h000300; exp_rdy[0]  = 1'b1;
        drop[1] = 1'b1; exp_uf[1] = 1'b1;
        exp_data[2]  = 24'h000301; exp_rdy[2]  = 1'b1;
        exp_data[3]  = 24'h000302; exp_rdy[3]  = 1'b1;
        exp_data[8]  = 24'h000303; exp_rdy[8]  = 1'b1;
        drop[9] = 1'b1; exp_uf[9] = 1'b1;
        exp_data[10] = 24'h000304; exp_rdy[10] = 1'b1;
        exp_data[11] = 24'h000305; exp_rdy[11] = 1'b1;
        run_frame(3, 8, 16'h000F, 16'h0060, 1'b1, -1, -1);
        chk("t4 UNDERFLOW_CNT", 32'(UNDERFLOW_CNT), 32'd2);

        // SOF arrives at line 1 pixel 2: rest of the frame black
        clear_exp();
        exp_data[0] = 24'h000400; exp_rdy[0] = 1'b1;
        exp_data[1] = 24'h000401; exp_rdy[1] = 1'b1;
        exp_data[2] = 24'h000402; exp_rdy[2] = 1'b1;
        exp_data[3] = 24'h000403; exp_rdy[3] = 1'b1;
        exp_data[8] = 24'h000404; exp_rdy[8] = 1'b1;
        exp_data[9] = 24'h000405; exp_rdy[9] = 1'b1;
        run_frame(4, 8, 16'h000F, 16'h0060, 1'b1, -1, -1);

        clear_exp(); lock_frame(24'h000500, 8, 4);
        run_frame(5, 8, 16'h000F, 16'h0060, 1'b1, -1, -1);
        chk("t5 UNDERFLOW_CNT", 32'(UNDERFLOW_CNT), 32'd2);

        // H_ACTIVE 4->6 mid-frame, new geometry next frame, then EN low
        clear_exp(); lock_frame(24'h000600, 8, 4);
        run_frame(6, 8, 16'h000F, 16'h0060, 1'b1, 20, -1);
        clear_exp(); lock_frame(24'h000700, 10, 6);
        run_frame(7, 10, 16'h003F, 16'h0180, 1'b1, -1, 25);
        tick();
        chk("t6 idle DE", 32'(HDMI_DE), 32'd0);
        chk("t6 idle FRAME_START", 32'(FRAME_START), 32'd0);
        chk("t6 idle HSYNC", 32'(HDMI_HSYNC), 32'd0);
        chk("t6 idle S_READY", 32'(S_READY), 32'd0);
        chk("t6 idle UNDERFLOW_CNT", 32'(UNDERFLOW_CNT), 32'd2);

        EN = 1'b1;
        tick();
        chk("en rise UNDERFLOW_CNT", 32'(UNDERFLOW_CNT), 32'd0);
        EN = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
